// File: rtl/video_axi4s_frame_checker_if.sv
// Stream + Wishbone bundle for the video frame checker.
// master = source/bus host side, slave = checker side.
interface video_axi4s_frame_checker_if #(
    parameter int TUSER_WIDTH  = 1,
    parameter int TDATA_WIDTH  = 24,
    parameter int WB_ADR_WIDTH = 8,
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
    logic [TUSER_WIDTH-1:0]  s_axi4s_tuser;
    logic                    s_axi4s_tlast;
    logic [TDATA_WIDTH-1:0]  s_axi4s_tdata;
    logic                    s_axi4s_tvalid;
    logic                    s_axi4s_tready;

    logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
    logic                    s_wb_we_i;
    logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
    logic                    s_wb_stb_i;
    logic                    s_wb_ack_o;

    modport master (
        output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
        input  s_axi4s_tready,
        output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        input  s_wb_dat_o, s_wb_ack_o
    );

    modport slave (
        input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
        output s_axi4s_tready,
        input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        output s_wb_dat_o, s_wb_ack_o
    );
endinterface

// File: rtl/video_axi4s_frame_checker.sv
// AXI4-Stream video sink checking SOF/EOL framing against WIDTH x HEIGHT, status over Wishbone.
// Optional per-frame pixel checksum: define VIDEO_AXI4S_FRAME_CHECKER_CHECKSUM_EN.
module video_axi4s_frame_checker #(
    parameter int TUSER_WIDTH  = 1,
    parameter int TDATA_WIDTH  = 24,
    parameter int X_WIDTH      = 12,
    parameter int Y_WIDTH      = 12,
    parameter int WB_ADR_WIDTH = 8,
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter bit INIT_ENABLE  = 1'b1,
    parameter int INIT_WIDTH   = 640,
    parameter int INIT_HEIGHT  = 480
) (
    input  logic                               clk,
    input  logic                               reset,
    video_axi4s_frame_checker_if.slave         bus,
    output logic                               frame_start,
    output logic                               frame_end,
    output logic                               error
);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL    = WB_ADR_WIDTH'(0);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_WIDTH  = WB_ADR_WIDTH'(1);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_HEIGHT = WB_ADR_WIDTH'(2);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_FCNT   = WB_ADR_WIDTH'(3);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_ERR    = WB_ADR_WIDTH'(4);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_POS    = WB_ADR_WIDTH'(5);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CKS    = WB_ADR_WIDTH'(6);

    typedef enum logic {WAIT_SOF, IN_FRAME} state_e;

    state_e               state_q, state_d;
    logic [X_WIDTH-1:0]   x_q, x_d, width_q, width_d, wsh_q, wsh_d;
    logic [Y_WIDTH-1:0]   y_q, y_d, height_q, height_d, hsh_q, hsh_d;
    logic                 ctl_en_q, ctl_en_d;
    logic [31:0]          fcnt_q, fcnt_d;
    logic [3:0]           err_q, err_d;
    logic                 bad_q, bad_d;
    logic                 sof_p_q, eof_p_q, err_p_q;

    logic [TUSER_WIDTH-1:0]  tuser;
    logic [TDATA_WIDTH-1:0]  tdata;
    logic [WB_ADR_WIDTH-1:0] adr;
    logic                    tlast;

    logic                 beat, sof_beat, pix, frame_done;
    logic [X_WIDTH-1:0]   px, w_sel, w_m1;
    logic [Y_WIDTH-1:0]   py, h_sel, h_m1;
    logic [3:0]           hw_err;
    logic [31:0]          cks;

    assign tuser = bus.s_axi4s_tuser;
    assign tdata = bus.s_axi4s_tdata;
    assign tlast = bus.s_axi4s_tlast;
    assign adr   = bus.s_wb_adr_i;

    assign bus.s_axi4s_tready = ctl_en_q;
    assign frame_start        = sof_p_q;
    assign frame_end          = eof_p_q;
    assign error              = err_p_q;

    // An SOF beat is evaluated as pixel (0,0) against the freshly loaded geometry.
    assign beat     = bus.s_axi4s_tvalid & ctl_en_q;
    assign sof_beat = beat & tuser[0];
    assign pix      = sof_beat | (beat & (state_q == IN_FRAME));
    assign px       = sof_beat ? '0 : x_q;
    assign py       = sof_beat ? '0 : y_q;
    assign w_sel    = sof_beat ? width_q  : wsh_q;
    assign h_sel    = sof_beat ? height_q : hsh_q;
    assign w_m1     = (w_sel == '0) ? '0 : w_sel - X_WIDTH'(1);
    assign h_m1     = (h_sel == '0) ? '0 : h_sel - Y_WIDTH'(1);
    assign frame_done = pix & tlast & (py == h_m1);

    always_comb begin
        hw_err = '0;
        if (beat) begin
            if (state_q == WAIT_SOF && !tuser[0]) begin
                hw_err[0] = 1'b1;
            end else begin
                hw_err[1] = sof_beat && (state_q == IN_FRAME) && (x_q != '0 || y_q != '0);
                hw_err[2] = tlast && (px < w_m1);
                hw_err[3] = !tlast && (px == w_m1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        wsh_d   = wsh_q;
        hsh_d   = hsh_q;
        bad_d   = bad_q;
        fcnt_d  = fcnt_q;
        if (pix) begin
            if (sof_beat) begin
                wsh_d = width_q;
                hsh_d = height_q;
            end
            // An early SOF blames the aborted frame, so the restarted one starts clean.
            bad_d   = (sof_beat ? 1'b0 : bad_q) | hw_err[2] | hw_err[3];
            state_d = IN_FRAME;
            if (tlast) begin
                x_d = '0;
                y_d = py + Y_WIDTH'(1);
            end else begin
                x_d = (&px) ? px : px + X_WIDTH'(1);
                y_d = py;
            end
            if (frame_done) begin
                state_d = WAIT_SOF;
                x_d     = '0;
                y_d     = '0;
                if (!bad_d) fcnt_d = fcnt_q + 32'd1;
            end
        end
    end

    logic [WB_DAT_WIDTH-1:0] wmask, wdat, rdata;
    logic                    wr;

    assign wr   = bus.s_wb_stb_i & bus.s_wb_we_i;
    assign wdat = bus.s_wb_dat_i & wmask;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < WB_SEL_WIDTH; b++) wmask[b*8 +: 8] = {8{bus.s_wb_sel_i[b]}};
    end

    always_comb begin
        ctl_en_d = ctl_en_q;
        width_d  = width_q;
        height_d = height_q;
        if (wr && adr == ADR_CTL)    ctl_en_d = (ctl_en_q & ~wmask[0]) | wdat[0];
        if (wr && adr == ADR_WIDTH)  width_d  = X_WIDTH'((WB_DAT_WIDTH'(width_q) & ~wmask) | wdat);
        if (wr && adr == ADR_HEIGHT) height_d = Y_WIDTH'((WB_DAT_WIDTH'(height_q) & ~wmask) | wdat);
        // Hardware set wins over a same-cycle clear.
        err_d = (err_q & ~((wr && adr == ADR_ERR) ? wdat[3:0] : 4'b0)) | hw_err;
    end

    always_comb begin
        rdata = '0;
        case (adr)
            ADR_CTL:    rdata = WB_DAT_WIDTH'(ctl_en_q);
            ADR_WIDTH:  rdata = WB_DAT_WIDTH'(width_q);
            ADR_HEIGHT: rdata = WB_DAT_WIDTH'(height_q);
            ADR_FCNT:   rdata = WB_DAT_WIDTH'(fcnt_q);
            ADR_ERR:    rdata = WB_DAT_WIDTH'(err_q);
            ADR_POS:    rdata = WB_DAT_WIDTH'({16'(y_q), 16'(x_q)});
            ADR_CKS:    rdata = WB_DAT_WIDTH'(cks);
            default:    rdata = '0;
        endcase
    end

    assign bus.s_wb_dat_o = rdata;
    assign bus.s_wb_ack_o = bus.s_wb_stb_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            width_q  <= X_WIDTH'(INIT_WIDTH);
            height_q <= Y_WIDTH'(INIT_HEIGHT);
            wsh_q    <= X_WIDTH'(INIT_WIDTH);
            hsh_q    <= Y_WIDTH'(INIT_HEIGHT);
            ctl_en_q <= INIT_ENABLE;
            fcnt_q   <= '0;
            err_q    <= '0;
            bad_q    <= 1'b0;
            sof_p_q  <= 1'b0;
            eof_p_q  <= 1'b0;
            err_p_q  <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            width_q  <= width_d;
            height_q <= height_d;
            wsh_q    <= wsh_d;
            hsh_q    <= hsh_d;
            ctl_en_q <= ctl_en_d;
            fcnt_q   <= fcnt_d;
            err_q    <= err_d;
            bad_q    <= bad_d;
            sof_p_q  <= sof_beat;
            eof_p_q  <= frame_done;
            err_p_q  <= |hw_err;
        end
    end

`ifdef VIDEO_AXI4S_FRAME_CHECKER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d, cks_q, cks_d;

    always_comb begin
        sum_d = sum_q;
        cks_d = cks_q;
        if (pix) sum_d = (sof_beat ? 32'd0 : sum_q) + 32'(tdata);
        if (frame_done) cks_d = sum_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            cks_q <= '0;
        end else begin
            sum_q <= sum_d;
            cks_q <= cks_d;
        end
    end

    assign cks = cks_q;
    logic unused_bits;
    assign unused_bits = ^tuser;
`else
    assign cks = '0;
    logic unused_bits;
    assign unused_bits = ^{tuser, tdata};
`endif
endmodule

// File: tb/tb_video_axi4s_frame_checker.sv
// Self-checking bench for video_axi4s_frame_checker: register table, directed framing cases,
// and randomized frames checked against a line-length based frame model.
module tb_video_axi4s_frame_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_start, frame_end, error;

    video_axi4s_frame_checker_if bus ();

    video_axi4s_frame_checker dut (
        .clk(clk), .reset(reset), .bus(bus),
        .frame_start(frame_start), .frame_end(frame_end), .error(error)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    int beats = 0, n_sof = 0, n_eof = 0, n_errp = 0;
    int eof_at[$];

    // Pulses are observed one cycle after their beat; record the beat count at frame_end.
    always @(negedge clk) begin
        if (frame_start) n_sof++;
        if (frame_end) begin n_eof++; eof_at.push_back(beats); end
        if (error) n_errp++;
        if (bus.s_axi4s_tvalid && bus.s_axi4s_tready) beats++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cks_model(input logic [31:0] s);
`ifdef VIDEO_AXI4S_FRAME_CHECKER_CHECKSUM_EN
        return s;
`else
        return 32'd0 & s;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.s_wb_adr_i = a; bus.s_wb_dat_i = d; bus.s_wb_sel_i = s;
        bus.s_wb_we_i = 1'b1; bus.s_wb_stb_i = 1'b1;
        @(posedge clk); #1;
        bus.s_wb_stb_i = 1'b0; bus.s_wb_we_i = 1'b0;
    endtask

    task automatic wb_rd(input logic [7:0] a, output logic [31:0] d);
        bus.s_wb_adr_i = a; bus.s_wb_we_i = 1'b0; bus.s_wb_sel_i = 4'hF; bus.s_wb_stb_i = 1'b1;
        @(negedge clk);
        d = bus.s_wb_dat_o;
        @(posedge clk); #1;
        bus.s_wb_stb_i = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_rd(a, d);
        check(name, d, exp);
    endtask

    task automatic beat(input bit u, input bit l, input logic [23:0] d);
        bit ok;
        int n;
        bus.s_axi4s_tuser = u; bus.s_axi4s_tlast = l; bus.s_axi4s_tdata = d;
        bus.s_axi4s_tvalid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.s_axi4s_tready;
            @(posedge clk);
            n++;
        end
        #1 bus.s_axi4s_tvalid = 1'b0;
        if (!ok) begin
            nchk++; nerr++;
            $display("FAIL beat_timeout: tready stayed 0, required 1");
        end
    endtask

    task automatic send_frame(input int w, input int h, input int base, output logic [31:0] s);
        s = 0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                logic [23:0] d;
                d = 24'(base + y * w + x);
                s += 32'(d);
                beat(x == 0 && y == 0, x == w - 1, d);
            end
    endtask

    typedef struct {
        bit          we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[15];
    int b0, k0, s0, e0, p0, w, h, nf, junk, len, exp_cnt, exp_errp;
    logic [3:0]  exp_err;
    logic [31:0] fc0, sum, s, d32;
    logic [23:0] d;
    bit good;

    initial begin
        vt[0]  = '{0, 8'd0, 32'h0,        4'h0,    32'd1};
        vt[1]  = '{0, 8'd1, 32'h0,        4'h0,    32'd640};
        vt[2]  = '{0, 8'd2, 32'h0,        4'h0,    32'd480};
        vt[3]  = '{0, 8'd3, 32'h0,        4'h0,    32'd0};
        vt[4]  = '{0, 8'd4, 32'h0,        4'h0,    32'd0};
        vt[5]  = '{0, 8'd5, 32'h0,        4'h0,    32'd0};
        vt[6]  = '{0, 8'd6, 32'h0,        4'h0,    32'd0};
        vt[7]  = '{0, 8'd7, 32'h0,        4'h0,    32'd0};
        vt[8]  = '{1, 8'd1, 32'h0000_0123, 4'b0001, 32'h223};
        vt[9]  = '{1, 8'd2, 32'hFFFF_FFFF, 4'b1111, 32'hFFF};
        vt[10] = '{1, 8'd2, 32'h0000_0A55, 4'b0010, 32'hAFF};
        vt[11] = '{1, 8'd3, 32'h0000_1234, 4'b1111, 32'd0};
        vt[12] = '{1, 8'd7, 32'hDEAD_BEEF, 4'b1111, 32'd0};
        vt[13] = '{1, 8'd0, 32'h0000_0000, 4'b0010, 32'd1};
        vt[14] = '{1, 8'd4, 32'h0000_000F, 4'b1111, 32'd0};

        bus.s_axi4s_tvalid = 1'b0; bus.s_axi4s_tuser = '0; bus.s_axi4s_tlast = 1'b0;
        bus.s_axi4s_tdata = '0; bus.s_wb_stb_i = 1'b0; bus.s_wb_we_i = 1'b0;
        bus.s_wb_adr_i = '0; bus.s_wb_dat_i = '0; bus.s_wb_sel_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_tready", 32'(bus.s_axi4s_tready), 32'd1);
        check("reset_pulses", {29'd0, frame_start, frame_end, error}, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            if (vt[i].we) wb_wr(vt[i].adr, vt[i].dat, vt[i].sel);
            rd_chk($sformatf("reg_vec%0d", i), vt[i].adr, vt[i].exp);
        end

        // 1: three clean 160x120 frames, continuous tvalid
        wb_wr(1, 160, 4'hF); wb_wr(2, 120, 4'hF);
        b0 = beats; k0 = eof_at.size();
        for (int f = 0; f < 3; f++) send_frame(160, 120, f * 19200, sum);
        idle(2);
        check("t1_eof_count", 32'(eof_at.size() - k0), 32'd3);
        for (int i = 0; i < 3; i++)
            if (eof_at.size() > k0 + i) check($sformatf("t1_eof_beat%0d", i), 32'(eof_at[k0 + i] - b0), 32'(19200 * (i + 1)));
        rd_chk("t1_fcount", 3, 32'd3);
        rd_chk("t1_err", 4, 32'd0);
        rd_chk("t1_cks", 6, cks_model(sum));

        // 2: junk before first SOF, then a clean 4x2 frame
        wb_wr(1, 4, 4'hF); wb_wr(2, 2, 4'hF);
        for (int i = 0; i < 5; i++) beat(0, i == 4, 24'(i));
        send_frame(4, 2, 100, sum);
        idle(2);
        rd_chk("t2_err", 4, 32'h1);
        rd_chk("t2_fcount", 3, 32'd4);
        wb_wr(4, 32'h1, 4'hF);
        rd_chk("t2_err_w1c", 4, 32'h0);

        // 3: short line 0, frame ends after 7 beats and is not counted
        b0 = beats; k0 = eof_at.size();
        for (int x = 0; x < 3; x++) beat(x == 0, x == 2, 24'(x));
        for (int x = 0; x < 4; x++) beat(0, x == 3, 24'(x));
        idle(2);
        check("t3_eof_count", 32'(eof_at.size() - k0), 32'd1);
        if (eof_at.size() > k0) check("t3_eof_beat", 32'(eof_at[k0] - b0), 32'd7);
        rd_chk("t3_err", 4, 32'h4);
        rd_chk("t3_fcount_bad", 3, 32'd4);
        send_frame(4, 2, 0, sum);
        idle(2);
        rd_chk("t3_fcount_good", 3, 32'd5);
        wb_wr(4, 32'hF, 4'hF);

        // 4: SOF re-asserted at (1,0)
        s0 = n_sof; p0 = n_errp;
        beat(1, 0, 24'd0);
        beat(1, 0, 24'd1);
        for (int x = 1; x < 4; x++) beat(0, x == 3, 24'(x));
        for (int x = 0; x < 4; x++) beat(0, x == 3, 24'(x));
        idle(2);
        check("t4_sof_pulses", 32'(n_sof - s0), 32'd2);
        check("t4_err_pulses", 32'(n_errp - p0), 32'd1);
        rd_chk("t4_err", 4, 32'h2);
        rd_chk("t4_fcount", 3, 32'd6);
        wb_wr(4, 32'hF, 4'hF);

        // 5: WIDTH change mid-frame applies at next SOF only
        beat(1, 0, 24'd0); beat(0, 0, 24'd1);
        wb_wr(1, 8, 4'hF);
        beat(0, 0, 24'd2); beat(0, 1, 24'd3);
        for (int x = 0; x < 4; x++) beat(0, x == 3, 24'(x));
        send_frame(8, 2, 7, sum);
        idle(2);
        rd_chk("t5_err", 4, 32'h0);
        rd_chk("t5_fcount", 3, 32'd8);

        // 6: checksum of 1..4, then enable toggled mid-frame
        wb_wr(1, 2, 4'hF); wb_wr(2, 2, 4'hF);
        beat(1, 0, 24'd1); beat(0, 1, 24'd2); beat(0, 0, 24'd3); beat(0, 1, 24'd4);
        idle(2);
        rd_chk("t6_cks", 6, cks_model(32'd10));
        wb_wr(1, 4, 4'hF);
        beat(1, 0, 24'd0); beat(0, 0, 24'd1);
        wb_wr(0, 32'h0, 4'hF);
        @(negedge clk);
        check("t6_tready_off", 32'(bus.s_axi4s_tready), 32'd0);
        @(posedge clk); #1;
        rd_chk("t6_pos", 5, 32'h0000_0002);
        idle(3);
        rd_chk("t6_pos_held", 5, 32'h0000_0002);
        wb_wr(0, 32'h1, 4'hF);
        beat(0, 0, 24'd2); beat(0, 1, 24'd3);
        for (int x = 0; x < 4; x++) beat(0, x == 3, 24'(x));
        idle(2);
        rd_chk("t6_err", 4, 32'h0);
        rd_chk("t6_fcount", 3, 32'd10);

        // 7: zero geometry behaves as 1x1
        wb_wr(1, 0, 4'hF); wb_wr(2, 0, 4'hF);
        beat(1, 1, 24'd5);
        idle(2);
        rd_chk("t7_fcount", 3, 32'd11);
        rd_chk("t7_cks", 6, cks_model(32'd5));
        beat(1, 0, 24'd0); beat(0, 1, 24'd0);
        idle(2);
        rd_chk("t7_err_long", 4, 32'h8);
        rd_chk("t7_fcount_bad", 3, 32'd11);
        wb_wr(4, 32'hF, 4'hF);

        // 8: W1C of ERR[0] in the same cycle as its hardware set
        beat(0, 0, 24'd0);
        bus.s_axi4s_tuser = 1'b0; bus.s_axi4s_tvalid = 1'b1;
        bus.s_wb_adr_i = 4; bus.s_wb_dat_i = 32'h1; bus.s_wb_sel_i = 4'hF;
        bus.s_wb_we_i = 1'b1; bus.s_wb_stb_i = 1'b1;
        @(posedge clk); #1;
        bus.s_axi4s_tvalid = 1'b0; bus.s_wb_stb_i = 1'b0; bus.s_wb_we_i = 1'b0;
        rd_chk("t8_err_race", 4, 32'h1);
        wb_wr(4, 32'h1, 4'hF);
        rd_chk("t8_err_clear", 4, 32'h0);

        // Randomized frames: a frame counts only if every line has exactly W beats.
        for (int it = 0; it < 8; it++) begin
            w = $urandom_range(1, 6); h = $urandom_range(1, 4); nf = $urandom_range(1, 3);
            exp_cnt = 0; exp_errp = 0; exp_err = 4'h0; sum = 0;
            s0 = n_sof; e0 = n_eof;
            p0 = n_errp;
            wb_rd(3, fc0);
            wb_wr(1, 32'(w), 4'hF); wb_wr(2, 32'(h), 4'hF);
            for (int f = 0; f < nf; f++) begin
                junk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                for (int j = 0; j < junk; j++) begin
                    d32 = $urandom;
                    beat(0, d32[0], 24'(d32));
                    exp_err[0] = 1'b1; exp_errp++;
                end
                good = 1'b1; sum = 0;
                for (int y = 0; y < h; y++) begin
                    len = w;
                    case ($urandom_range(0, 5))
                        0: if (w > 1) len = $urandom_range(1, w - 1);
                        1: len = w + $urandom_range(1, 2);
                        default: len = w;
                    endcase
                    if (len < w) begin exp_err[2] = 1'b1; good = 1'b0; exp_errp++; end
                    if (len > w) begin exp_err[3] = 1'b1; good = 1'b0; exp_errp++; end
                    for (int x = 0; x < len; x++) begin
                        d = 24'($urandom);
                        sum += 32'(d);
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                        beat(x == 0 && y == 0, x == len - 1, d);
                    end
                end
                if (good) exp_cnt++;
            end
            idle(3);
            check($sformatf("rnd%0d_sof", it), 32'(n_sof - s0), 32'(nf));
            check($sformatf("rnd%0d_eof", it), 32'(n_eof - e0), 32'(nf));
            check($sformatf("rnd%0d_errp", it), 32'(n_errp - p0), 32'(exp_errp));
            rd_chk($sformatf("rnd%0d_fcount", it), 3, fc0 + 32'(exp_cnt));
            rd_chk($sformatf("rnd%0d_err", it), 4, 32'(exp_err));
            rd_chk($sformatf("rnd%0d_cks", it), 6, cks_model(sum));
            wb_wr(4, 32'hF, 4'hF);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/video_axi4s_frame_checker.md
Name: video_axi4s_frame_checker

Overview:
AXI4-Stream video sink that consumes a raster stream and checks its framing against a programmed geometry.
- Framing: tuser[0] marks start-of-frame; tlast marks end-of-line.
- Status: counts good frames and latches framing errors, all readable through a Wishbone slave port.
- Use: it is the receiving end of the video source model and of the segmentation/colour pipelines, instantiated at the output of any video block under test or in hardware.

Parameters:
TUSER_WIDTH, 1, width of s_axi4s_tuser; only bit 0 is interpreted.
TDATA_WIDTH, 24, pixel data width.
X_WIDTH, 12, width of the x counter and WIDTH register.
Y_WIDTH, 12, width of the y counter and HEIGHT register.
WB_ADR_WIDTH, 8, Wishbone word-address width.
WB_DAT_WIDTH, 32, Wishbone data width.
WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width.
INIT_ENABLE, 1'b1, reset value of CTL.enable.
INIT_WIDTH, 640, reset value of WIDTH.
INIT_HEIGHT, 480, reset value of HEIGHT.

Ports:
reset  in  1  asynchronous, active-high reset
clk  in  1  single clock for stream and Wishbone
s_axi4s_tuser  in  TUSER_WIDTH  bit 0 = start of frame
s_axi4s_tlast  in  1  end of line
s_axi4s_tdata  in  TDATA_WIDTH  pixel
s_axi4s_tvalid  in  1  beat valid
s_axi4s_tready  out  1  = CTL.enable (registered)
frame_start  out  1  one-cycle pulse on an accepted SOF beat
frame_end  out  1  one-cycle pulse on the last beat of a frame
error  out  1  one-cycle pulse whenever any error bit is set
s_wb_adr_i  in  WB_ADR_WIDTH  word address
s_wb_dat_i  in  WB_DAT_WIDTH  write data
s_wb_dat_o  out  WB_DAT_WIDTH  read data
s_wb_we_i  in  1  write enable
s_wb_sel_i  in  WB_SEL_WIDTH  byte selects
s_wb_stb_i  in  1  strobe
s_wb_ack_o  out  1  = s_wb_stb_i (zero wait states)

Behaviour:
- Reset (asynchronous): state=WAIT_SOF; x=0, y=0; FRAME_COUNT=0; ERR=0; CTL=INIT_ENABLE; WIDTH/HEIGHT and their shadows = INIT values; all pulse outputs 0; tready=INIT_ENABLE.
- Beat accepted = tvalid & tready. Nothing changes on other cycles.
- WAIT_SOF:
  - Beat with tuser[0]=0: discarded; set ERR[0] (no_sof).
  - Beat with tuser[0]=1: load shadows from WIDTH/HEIGHT; frame_start=1; clear frame_bad; treat as pixel (0,0); go IN_FRAME.
- IN_FRAME, per beat:
  - tuser[0]=1 with (x,y)≠(0,0): set ERR[1] (early_sof); frame is not counted; restart as a new frame at (0,0); frame_start=1.
  - tlast=1 with x<w-1: set ERR[2] (short_line).
  - tlast=0 with x==w-1: set ERR[3] (long_line).
  - Any error sets frame_bad.
  - Only tlast ends a line: next x=0, y=y+1. Otherwise x=x+1, saturating at all-ones.
  - tlast with y==h-1 ends the frame: frame_end=1; if !frame_bad, FRAME_COUNT+=1 (32-bit wrap); go WAIT_SOF.
  - Frames are never longer than h lines.
- Pulses (frame_start, frame_end, error): registered, asserted in the cycle after the accepted beat.
- Registers (word address):
  - 0 CTL RW: bit0 enable.
  - 1 WIDTH RW.
  - 2 HEIGHT RW.
  - 3 FRAME_COUNT RO; writes ignored.
  - 4 ERR: sticky, write-1-to-clear.
  - 5 POS RO: {y[15:0], x[15:0]}.
  - 6 CHECKSUM RO.
  - Other addresses read 0.
- Register access rules:
  - Writes honour byte selects.
  - Reads are combinational.
  - A write with stb & we & ack takes effect at the next edge.
  - WIDTH/HEIGHT writes take effect at the next SOF only.
  - W1C of an ERR bit in the same cycle as a hardware set of that bit leaves it set.
- Clearing CTL.enable mid-frame drops tready at the next edge. Position state is held; reception continues when enable is set again.
- WIDTH or HEIGHT = 0 is treated as 1.

Optional Feature:
Macro: VIDEO_AXI4S_FRAME_CHECKER_CHECKSUM_EN.
- Defined:
  - Running 32-bit sum of zero-extended tdata over the current frame; reset to tdata on SOF.
  - Latched into CHECKSUM at frame_end, whether or not frame_bad is set.
  - Reset value 0.
- Undefined: no accumulator logic; CHECKSUM reads 0.

Test Plan:
1. WIDTH=160, HEIGHT=120, clean 160x120 stream, tvalid continuous, 3 frames -> FRAME_COUNT=3, ERR=0, frame_end pulses at beats 19200/38400/57600.
2. Stream starting mid-frame (tuser=0 for 5 beats) then a clean 4x2 frame with WIDTH=4, HEIGHT=2 -> ERR=0x1, FRAME_COUNT=1; W1C 0x1 -> ERR=0.
3. WIDTH=4, HEIGHT=2; line 0 has tlast on x=2 -> ERR[2]=1, line advances, frame ends after 7 beats, FRAME_COUNT=0; next clean frame -> FRAME_COUNT=1.
4. WIDTH=4, HEIGHT=2; SOF re-asserted at (1,0) -> ERR[1]=1, frame_start pulses twice, restarted frame counted -> FRAME_COUNT=1.
5. Write WIDTH=8 mid-frame of a 4x2 frame -> current frame completes clean at 4 pixels/line; the following 8x2 frame is also clean; FRAME_COUNT=2.
6. With CHECKSUM_EN, 2x2 frame with tdata 1,2,3,4 -> CHECKSUM=10. Deassert enable mid-frame -> tready=0 next cycle, POS held; re-enable -> frame completes with ERR=0.
